// File: rtl/dmem_lsu_if.sv
// Core-to-LSU data port: one request held until the single-cycle response pulse.
interface dmem_lsu_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        stall;
    logic        rvalid;
    logic [31:0] rdata;
    logic        fault;

    modport master (output req, we, funct3, addr, wdata,
                    input  ready, stall, rvalid, rdata, fault);
    modport slave  (input  req, we, funct3, addr, wdata,
                    output ready, stall, rvalid, rdata, fault);
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit over a wait-state word RAM: byte/half/word access with extension,
// alignment/illegal-op faulting and a stall that freezes the core until the response.
module dmem_lsu #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    dmem_lsu_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [CW-1:0] cnt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic [31:0] mem [DEPTH];

    logic        accept, do_op, bad;
    logic [AW-1:0] widx;
    logic [31:0] word, load_val, wlane;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [3:0]  be;

    assign accept = (state == IDLE) && bus.req;
    assign do_op  = (state == WAIT) && (cnt == '0);

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req) state_nx = WAIT;
            WAIT:    if (cnt == '0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs; stall is combinational from req so the core freezes in the request cycle
    always_comb begin
        bus.ready  = (state == IDLE);
        bus.stall  = accept || (state == WAIT);
        bus.rvalid = (state == RESP);
    end

    assign bus.rdata = rdata_q;
    assign bus.fault = fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= bus.we;
                f3_q    <= bus.funct3;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                cnt     <= CW'(LATENCY - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (do_op) begin
                fault_q <= bad;
                rdata_q <= (bad || we_q) ? 32'h0 : load_val;
            end
        end
    end

    // Stores with the unsigned encodings have no meaning and fault like illegal funct3.
    always_comb begin
        bad = 1'b0;
        case (f3_q)
            3'b000:  bad = 1'b0;
            3'b001:  bad = addr_q[0];
            3'b010:  bad = |addr_q[1:0];
            3'b100:  bad = we_q;
            3'b101:  bad = we_q | addr_q[0];
            default: bad = 1'b1;
        endcase
    end

    assign widx = AW'(addr_q[31:2] % 30'(DEPTH));
    assign word = mem[widx];
    assign bsel = word[{addr_q[1:0], 3'b000} +: 8];
    assign hsel = addr_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_val = word;
        be       = 4'b1111;
        wlane    = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                load_val = {{24{bsel[7] & ~f3_q[2]}}, bsel};
                be       = 4'b0001 << addr_q[1:0];
                wlane    = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                load_val = {{16{hsel[15] & ~f3_q[2]}}, hsel};
                be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane    = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // RAM is intentionally not reset; lanes outside the byte enables keep their contents.
    always_ff @(posedge clk) begin
        if (do_op && we_q && !bad) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench: the same directed program runs on LATENCY 2, 1 and 4 builds.
module tb_dmem_lsu;
    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        ef;
        logic        chk;
        logic        rmid;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        logic        ef;
        logic        chk;
        int          acc;
        int          idx;
    } exp_t;

    localparam int NV = 23;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t vecs [NV];

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] exp, logic ef, logic chk, logic rmid);
        vec_t v;
        v.we = we; v.f3 = f3; v.a = a; v.wd = wd;
        v.exp = exp; v.ef = ef; v.chk = chk; v.rmid = rmid;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(1, 3'b010, 32'h64,  32'h12345678, 32'h0,        0, 0, 0);
        vecs[1]  = mk(0, 3'b010, 32'h64,  32'h0,        32'h12345678, 0, 1, 0);
        vecs[2]  = mk(1, 3'b000, 32'h65,  32'h000000AB, 32'h0,        0, 0, 0);
        vecs[3]  = mk(0, 3'b010, 32'h64,  32'h0,        32'h1234AB78, 0, 1, 0);
        vecs[4]  = mk(0, 3'b000, 32'h65,  32'h0,        32'hFFFFFFAB, 0, 1, 0);
        vecs[5]  = mk(0, 3'b100, 32'h65,  32'h0,        32'h000000AB, 0, 1, 0);
        vecs[6]  = mk(0, 3'b001, 32'h66,  32'h0,        32'h00001234, 0, 1, 0);
        vecs[7]  = mk(1, 3'b001, 32'h66,  32'h00008001, 32'h0,        0, 0, 0);
        vecs[8]  = mk(0, 3'b001, 32'h66,  32'h0,        32'hFFFF8001, 0, 1, 0);
        vecs[9]  = mk(0, 3'b101, 32'h66,  32'h0,        32'h00008001, 0, 1, 0);
        vecs[10] = mk(0, 3'b010, 32'h62,  32'h0,        32'h0,        1, 1, 0);
        vecs[11] = mk(1, 3'b001, 32'h67,  32'h0000FFFF, 32'h0,        1, 1, 0);
        vecs[12] = mk(0, 3'b010, 32'h64,  32'h0,        32'h8001AB78, 0, 1, 0);
        vecs[13] = mk(0, 3'b011, 32'h64,  32'h0,        32'h0,        1, 1, 0);
        vecs[14] = mk(1, 3'b100, 32'h64,  32'h00000055, 32'h0,        1, 1, 0);
        vecs[15] = mk(0, 3'b010, 32'h64,  32'h0,        32'h8001AB78, 0, 1, 0);
        vecs[16] = mk(0, 3'b000, 32'h67,  32'h0,        32'hFFFFFF80, 0, 1, 0);
        vecs[17] = mk(0, 3'b100, 32'h64,  32'h0,        32'h00000078, 0, 1, 0);
        vecs[18] = mk(1, 3'b010, 32'h68,  32'h11223344, 32'h0,        0, 0, 0);
        vecs[19] = mk(1, 3'b010, 32'h68,  32'hDEADBEEF, 32'h0,        0, 0, 1);
        vecs[20] = mk(0, 3'b010, 32'h68,  32'h0,        32'h11223344, 0, 1, 0);
        vecs[21] = mk(1, 3'b010, 32'h0,   32'hCAFEF00D, 32'h0,        0, 0, 0);
        vecs[22] = mk(0, 3'b010, 32'h100, 32'h0,        32'hCAFEF00D, 0, 1, 0);
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

        logic rst = 1'b1;
        logic fin = 1'b0;
        dmem_lsu_if bus();
        dmem_lsu #(.DEPTH(64), .LATENCY(LAT)) u_dut (.clk(clk), .reset(rst), .bus(bus));

        exp_t q[$];

        task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
            n_cmp++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL L%0d %s: got %h want %h", LAT, nm, act, exp);
            end
        endtask

        // Monitor: every response pops the oldest expectation.
        always @(negedge clk) begin
            if (rst === 1'b0 && bus.rvalid === 1'b1) begin
                exp_t e;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL L%0d spurious_rvalid: got rvalid=1 want no response", LAT);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("v%0d fault", e.idx), 32'(bus.fault), 32'(e.ef));
                    if (e.chk) chk($sformatf("v%0d rdata", e.idx), bus.rdata, e.exp);
                    chk($sformatf("v%0d latency", e.idx), 32'(cyc - e.acc), 32'(LAT));
                end
            end
        end

        initial begin
            bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = '0; bus.addr = '0; bus.wdata = '0;
            repeat (2) @(negedge clk);
            chk("reset ready",  32'(bus.ready),  32'd1);
            chk("reset stall",  32'(bus.stall),  32'd0);
            chk("reset rvalid", 32'(bus.rvalid), 32'd0);
            chk("reset rdata",  bus.rdata,       32'd0);
            chk("reset fault",  32'(bus.fault),  32'd0);
            rst = 1'b0;
            for (int i = 0; i < NV; i++) begin
                int ns;
                int t;
                exp_t e;
                @(negedge clk);
                chk($sformatf("v%0d ready", i), 32'(bus.ready), 32'd1);
                bus.req = 1'b1; bus.we = vecs[i].we; bus.funct3 = vecs[i].f3;
                bus.addr = vecs[i].a; bus.wdata = vecs[i].wd;
                #1;
                ns = bus.stall ? 1 : 0;
                if (!vecs[i].rmid) begin
                    e.exp = vecs[i].exp; e.ef = vecs[i].ef; e.chk = vecs[i].chk;
                    e.acc = cyc + 1; e.idx = i;
                    q.push_back(e);
                end
                @(posedge clk);
                if (vecs[i].rmid) begin
                    @(negedge clk);
                    rst = 1'b1;
                    #1 bus.req = 1'b0;
                    @(negedge clk);
                    chk("abort rvalid", 32'(bus.rvalid), 32'd0);
                    chk("abort ready",  32'(bus.ready),  32'd1);
                    rst = 1'b0;
                    repeat (LAT + 2) @(negedge clk);
                end else begin
                    for (t = 0; t < 20; t++) begin
                        @(negedge clk);
                        if (bus.rvalid) break;
                        if (bus.stall) ns++;
                    end
                    if (t == 20) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL L%0d v%0d timeout: got no rvalid want rvalid within 20 cycles", LAT, i);
                    end else begin
                        chk($sformatf("v%0d stall_cycles", i), 32'(ns), 32'(LAT + 1));
                    end
                end
            end
            @(negedge clk);
            bus.req = 1'b0;
            repeat (6) @(negedge clk);
            chk("pending responses", 32'(q.size()), 32'd0);
            fin = 1'b1;
        end
    end

    initial begin
        int c;
        for (c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (g_dut[0].fin && g_dut[1].fin && g_dut[2].fin) break;
        end
        if (c == 20000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL global_timeout: got unfinished drivers want all finished");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
